// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, funct codes, record kinds,
// FSM states and the instruction decode helper.
package alu_ctrl_pkg;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_MEM    = 2'd2,
    KIND_UNSUP  = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef struct packed {
    kind_e            kind;
    logic             wr_en;
    logic [RF_AW-1:0] wr_addr;
    logic             ovf_trap;  // signed op whose overflow cancels the write
  } decode_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic decode_t decode_ins(input logic [5:0]       op,
                                         input logic [5:0]       funct,
                                         input logic [RF_AW-1:0] rt,
                                         input logic [RF_AW-1:0] rd);
    decode_t d;
    d.kind     = KIND_UNSUP;
    d.wr_en    = 1'b0;
    d.wr_addr  = '0;
    d.ovf_trap = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct_supported(funct)) begin
          d.kind     = KIND_REG;
          d.wr_en    = 1'b1;
          d.wr_addr  = rd;
          d.ovf_trap = (funct == FN_ADD) || (funct == FN_SUB);
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d.kind     = KIND_REG;
        d.wr_en    = 1'b1;
        d.wr_addr  = rt;
        d.ovf_trap = (op == OP_ADDI);
      end
      OP_BEQ, OP_BNE: d.kind = KIND_BRANCH;
      OP_LW, OP_SW:   d.kind = KIND_MEM;
      default:        d.kind = KIND_UNSUP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// 32-entry register file: two captured read ports, one write port and a
// combinational debug port. Entry 0 is never written so it always reads 0.
module alu_regfile
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [RF_AW-1:0]  rd_addr_a,
  input  logic [RF_AW-1:0]  rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [RF_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RF_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [RF_DEPTH];

  // Storage: reset clears every entry; writes to entry 0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Operand capture: both read ports sample together when requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_en) begin
      rd_data_a <= regs[rd_addr_a];
      rd_data_b <= regs[rd_addr_b];
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the combinational MIPS alu.
//
// state | meaning
// IDLE  | ins_ready high, waiting for an instruction
// READ  | capture rf[rs] / rf[rt] into alu_a / alu_b
// EXEC  | alu settles; capture result, flags and record kind
// WB    | commit the register write if it is legal
// RESP  | completion record held until the consumer accepts it
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [DATA_W-1:0] ins,
  output logic [DATA_W-1:0] alu_ins,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [2:0]        alu_flgs,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [DATA_W-1:0] done_res,
  output logic [2:0]        done_flgs,
  output logic [1:0]        done_kind,
  output logic              branch_taken,
  input  logic [RF_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_e           state;
  decode_t          dec;
  logic             wb_en;
  logic [RF_AW-1:0] wb_addr;
  logic             rf_wr_en;

  assign dec = decode_ins(alu_ins[31:26], alu_ins[5:0], alu_ins[20:16], alu_ins[15:11]);

  // The write is decided in EXEC (flags are only valid then) and committed in WB
  assign rf_wr_en = (state == ST_WB) && wb_en;

  alu_regfile #(
    .DATA_W (DATA_W)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (state == ST_READ),
    .rd_addr_a (alu_ins[25:21]),
    .rd_addr_b (alu_ins[20:16]),
    .rd_data_a (alu_a),
    .rd_data_b (alu_b),
    .wr_en     (rf_wr_en),
    .wr_addr   (wb_addr),
    .wr_data   (done_res),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // Sequencer FSM with registered handshake and completion-record outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ins_ready    <= 1'b1;
      alu_ins      <= '0;
      done_valid   <= 1'b0;
      done_res     <= '0;
      done_flgs    <= '0;
      done_kind    <= '0;
      branch_taken <= 1'b0;
      retired_cnt  <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ins_valid) begin
            alu_ins   <= ins;
            ins_ready <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          done_res     <= alu_res;
          done_flgs    <= alu_flgs;
          done_kind    <= dec.kind;
          branch_taken <= (dec.kind == KIND_BRANCH) && alu_flgs[0];
          wb_en        <= dec.wr_en && !(dec.ovf_trap && alu_flgs[2]);
          wb_addr      <= dec.wr_addr;
          state        <= ST_WB;
        end
        ST_WB: begin
          done_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (done_ready) begin
            done_valid  <= 1'b0;
            retired_cnt <= retired_cnt + 1'b1;
            ins_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          done_valid <= 1'b0;
          ins_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural MIPS alu alongside.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [31:0] ins = '0;
  logic [31:0] alu_ins, alu_a, alu_b, alu_res;
  logic [2:0]  alu_flgs;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic [31:0] done_res;
  logic [2:0]  done_flgs;
  logic [1:0]  done_kind;
  logic        branch_taken;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [15:0] retired_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = 0;

  alu_seq_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins          (ins),
    .alu_ins      (alu_ins),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_flgs     (alu_flgs),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_res     (done_res),
    .done_flgs    (done_flgs),
    .done_kind    (done_kind),
    .branch_taken (branch_taken),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural alu: {flags, result}
  function automatic logic [34:0] alu_model(input logic [31:0] w, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] sx, zx, r;
    logic [2:0]  f;
    op = w[31:26]; fn = w[5:0]; sh = w[10:6];
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0, w[15:0]};
    r = '0; f = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00: r = b << sh;
          6'h02: r = b >> sh;
          6'h03: r = $signed(b) >>> sh;
          6'h04: r = b << a[4:0];
          6'h06: r = b >> a[4:0];
          6'h07: r = $signed(b) >>> a[4:0];
          6'h20, 6'h21: begin r = a + b; f[2] = (a[31] == b[31]) && (r[31] != a[31]); end
          6'h22, 6'h23: begin r = a - b; f[2] = (a[31] != b[31]) && (r[31] != a[31]); end
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2A: r = {31'b0, $signed(a) < $signed(b)};
          6'h2B: r = {31'b0, a < b};
          default: r = '0;
        endcase
      end
      6'h08, 6'h09: begin r = a + sx; f[2] = (a[31] == sx[31]) && (r[31] != a[31]); end
      6'h0A: r = {31'b0, $signed(a) < $signed(sx)};
      6'h0B: r = {31'b0, a < sx};
      6'h0C: r = a & zx;
      6'h0D: r = a | zx;
      6'h0E: r = a ^ zx;
      6'h04: begin r = a - b; f[0] = (a == b); end
      6'h05: begin r = a - b; f[0] = (a != b); end
      6'h23, 6'h2B: r = a + sx;
      default: r = '0;
    endcase
    f[1] = r[31];
    return {f, r};
  endfunction

  // Combinational alu attached to the sequencer
  always_comb {alu_flgs, alu_res} = alu_model(alu_ins, alu_a, alu_b);

  // Issue one instruction from a negedge in IDLE; returns at the negedge after the record handshake
  task automatic run_ins(input logic [31:0] w, output logic [31:0] res, output logic [2:0] fl,
                         output logic [1:0] kd, output logic bt, output int lat);
    int t;
    t = 0;
    while (!ins_ready && t < 50) begin @(negedge clk); t++; end
    if (!ins_ready) begin
      checks++; failures++;
      $display("FAIL ins_ready_timeout got=%0b want=1", ins_ready);
    end
    ins = w; ins_valid = 1'b1; last_accept = cyc;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!done_valid) begin
      checks++; failures++;
      $display("FAIL done_valid_timeout ins=%h got=%0b want=1", w, done_valid);
    end
    res = done_res; fl = done_flgs; kd = done_kind; bt = branch_taken;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] r;
  logic [2:0]  fl;
  logic [1:0]  kd;
  logic        bt;
  int          lat;

  task automatic test_reset();
    rst = 1'b1; ins_valid = 1'b0; done_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL reset_ins_ready got=%b want=1", ins_ready); end
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL reset_done_valid got=%b want=0", done_valid); end
    checks++; if (retired_cnt !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d want=0", retired_cnt); end
    checks++; if (alu_ins !== 32'd0 || alu_a !== 32'd0 || done_res !== 32'd0) begin
      failures++; $display("FAIL reset_regs alu_ins=%h alu_a=%h done_res=%h want=0", alu_ins, alu_a, done_res);
    end
  endtask

  task automatic test_addiu();
    run_ins(32'h24010004, r, fl, kd, bt, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL addiu_latency got=%0d want=4", lat); end
    checks++; if (kd !== 2'd0 || r !== 32'd4) begin failures++; $display("FAIL addiu_record kind=%0d res=%h want kind=0 res=4", kd, r); end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_data !== 32'd4) begin failures++; $display("FAIL addiu_rf1 got=%h want=4", dbg_data); end
    checks++; if (retired_cnt !== 16'd1) begin failures++; $display("FAIL addiu_retired got=%0d want=1", retired_cnt); end
    checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL addiu_ready_after got=%b want=1", ins_ready); end
  endtask

  task automatic test_shift_raw();
    int prev;
    run_ins(32'h24020001, r, fl, kd, bt, lat);
    prev = last_accept;
    run_ins(32'h00021880, r, fl, kd, bt, lat);
    checks++; if (last_accept - prev !== 5) begin failures++; $display("FAIL back_to_back_interval got=%0d want=5", last_accept - prev); end
    checks++; if (r !== 32'd4) begin failures++; $display("FAIL sll_res got=%h want=4", r); end
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_data !== 32'd4) begin failures++; $display("FAIL sll_rf3 got=%h want=4", dbg_data); end
    run_ins(32'h24000007, r, fl, kd, bt, lat);
    checks++; if (r !== 32'd7) begin failures++; $display("FAIL addiu_r0_res got=%h want=7", r); end
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin failures++; $display("FAIL r0_stays_zero got=%h want=0", dbg_data); end
  endtask

  task automatic test_overflow();
    run_ins(32'h00003027, r, fl, kd, bt, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL nor_res got=%h want=ffffffff", r); end
    run_ins(32'h00063842, r, fl, kd, bt, lat);
    checks++; if (r !== 32'h7FFFFFFF) begin failures++; $display("FAIL srl_res got=%h want=7fffffff", r); end
    run_ins(32'h00E14020, r, fl, kd, bt, lat);
    checks++; if (fl !== 3'b110 || r !== 32'h80000003) begin failures++; $display("FAIL add_ovf_record flgs=%b res=%h want flgs=110 res=80000003", fl, r); end
    dbg_addr = 5'd8; #1;
    checks++; if (dbg_data !== 32'd0) begin failures++; $display("FAIL add_ovf_suppressed rf8=%h want=0", dbg_data); end
    run_ins(32'h00E14821, r, fl, kd, bt, lat);
    checks++; if (fl !== 3'b110) begin failures++; $display("FAIL addu_flgs got=%b want=110", fl); end
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'h80000003) begin failures++; $display("FAIL addu_rf9 got=%h want=80000003", dbg_data); end
  endtask

  task automatic test_branch_mem();
    run_ins(32'h24050055, r, fl, kd, bt, lat);
    run_ins(32'h10210003, r, fl, kd, bt, lat);
    checks++; if (kd !== 2'd1 || bt !== 1'b1) begin failures++; $display("FAIL beq_taken kind=%0d taken=%b want kind=1 taken=1", kd, bt); end
    run_ins(32'h14210003, r, fl, kd, bt, lat);
    checks++; if (kd !== 2'd1 || bt !== 1'b0) begin failures++; $display("FAIL bne_not_taken kind=%0d taken=%b want kind=1 taken=0", kd, bt); end
    run_ins(32'h8C25000A, r, fl, kd, bt, lat);
    checks++; if (kd !== 2'd2 || r !== 32'd14 || bt !== 1'b0) begin failures++; $display("FAIL lw_record kind=%0d res=%h taken=%b want kind=2 res=e taken=0", kd, r, bt); end
    run_ins(32'hAC250008, r, fl, kd, bt, lat);
    checks++; if (kd !== 2'd2 || r !== 32'd12) begin failures++; $display("FAIL sw_record kind=%0d res=%h want kind=2 res=c", kd, r); end
    run_ins(32'h00002808, r, fl, kd, bt, lat);
    checks++; if (kd !== 2'd3) begin failures++; $display("FAIL unsup_kind got=%0d want=3", kd); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'h55) begin failures++; $display("FAIL rf5_unchanged got=%h want=55", dbg_data); end
    checks++; if (retired_cnt !== 16'd14) begin failures++; $display("FAIL retired_14 got=%0d want=14", retired_cnt); end
  endtask

  task automatic test_stall();
    int t;
    ins = 32'h240A0123; ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0; done_ready = 1'b0;
    t = 0;
    while (!done_valid && t < 20) begin @(negedge clk); t++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (done_valid !== 1'b1 || done_res !== 32'h123 || done_kind !== 2'd0 || ins_ready !== 1'b0 || retired_cnt !== 16'd14) begin
        failures++;
        $display("FAIL stall_hold cyc%0d valid=%b res=%h kind=%0d ready=%b cnt=%0d want 1/123/0/0/14",
                 i, done_valid, done_res, done_kind, ins_ready, retired_cnt);
      end
      @(negedge clk);
    end
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (done_valid !== 1'b0 || ins_ready !== 1'b1) begin failures++; $display("FAIL stall_release valid=%b ready=%b want 0/1", done_valid, ins_ready); end
    checks++; if (retired_cnt !== 16'd15) begin failures++; $display("FAIL stall_retired got=%0d want=15", retired_cnt); end
    @(negedge clk);
    checks++; if (retired_cnt !== 16'd15) begin failures++; $display("FAIL stall_retired_once got=%0d want=15", retired_cnt); end
    dbg_addr = 5'd10; #1;
    checks++; if (dbg_data !== 32'h123) begin failures++; $display("FAIL stall_rf10 got=%h want=123", dbg_data); end
  endtask

  task automatic test_reset_mid();
    int bad;
    ins = 32'h240B0009; ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (done_valid !== 1'b0 || ins_ready !== 1'b0) begin failures++; $display("FAIL exec_pre_reset valid=%b ready=%b want 0/0", done_valid, ins_ready); end
    rst = 1'b1; ins = 32'h240C0005; ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ins_valid = 1'b0;
    checks++; if (ins_ready !== 1'b1 || done_valid !== 1'b0) begin failures++; $display("FAIL midreset_hs ready=%b valid=%b want 1/0", ins_ready, done_valid); end
    checks++; if (retired_cnt !== 16'd0) begin failures++; $display("FAIL midreset_retired got=%0d want=0", retired_cnt); end
    checks++; if (alu_ins !== 32'd0 || done_res !== 32'd0 || alu_a !== 32'd0) begin
      failures++; $display("FAIL midreset_regs alu_ins=%h done_res=%h alu_a=%h want=0", alu_ins, done_res, alu_a);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      if (dbg_data !== 32'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_rf_clear nonzero=%0d want=0", bad); end
    @(negedge clk);
    checks++; if (ins_ready !== 1'b1 || done_valid !== 1'b0) begin failures++; $display("FAIL midreset_not_accepted ready=%b valid=%b want 1/0", ins_ready, done_valid); end
    run_ins(32'h24010004, r, fl, kd, bt, lat);
    checks++; if (r !== 32'd4 || retired_cnt !== 16'd1) begin failures++; $display("FAIL post_reset_run res=%h cnt=%0d want 4/1", r, retired_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addiu();
    test_shift_raw();
    test_overflow();
    test_branch_mem();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
